lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
// Load/store unit for the memory stage of the 5-stage RISC-V pipeline, directly downstream of the execute stage.
// It consumes alu_outM, write_dataM, mem_writeM, mem_sizeM and a read enable (mem_to_regM) and runs a request/grant/response
// transaction on the data-memory bus. It returns sign- or zero-extended read data to the M->W register and raises a stall
// until the access completes. Misaligned and illegal accesses, bus errors and timeouts are reported on err_m.
// PARAMETERS
// TIMEOUT_CYCLES  255  max cycles in REQ+WAIT before the access is aborted with an error (must be >=2, fits 8 bits)
// PORTS
// clk          in   1   pipeline clock
// reset        in   1   asynchronous, active-high reset
// valid_m      in   1   memory-stage slot holds a real instruction
// mem_read_m   in   1   load in M (mem_to_regM)
// mem_write_m  in   1   store in M (mem_writeM)
// mem_size_m   in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// addr_m       in   32  byte address (alu_outM)
// wdata_m      in   32  store data (write_dataM), right-aligned
// read_data_m  out  32  extended load data, to M->W register (read_dataM)
// stall_m      out  1   freeze F/D/E/M pipeline registers
// err_m        out  1   one-cycle access-fault flag, aligned with the stall_m=0 cycle of the faulting access
// dmem_req     out  1   bus request, held until dmem_gnt
// dmem_we      out  1   1 = write
// dmem_addr    out  32  word address ({addr_m[31:2],2'b00})
// dmem_be      out  4   byte enables
// dmem_wdata   out  32  lane-replicated store data
// dmem_gnt     in   1   request accepted this cycle
// dmem_rvalid  in   1   response (read data or write ack)
// dmem_rdata   in   32  read data, valid with dmem_rvalid
// dmem_err     in   1   bus error, sampled with dmem_rvalid
// BEHAVIOUR
// - Reset (async): state=IDLE, timeout counter=0; all registered outputs 0. stall_m, err_m, dmem_req read 0 while reset is high.
// - access = valid_m & (mem_read_m | mem_write_m). If both read and write are set, the write wins.
// - fault = misaligned (H with addr[0]=1, W with addr[1:0]!=0) or illegal size (011, 110, 111; 100/101 on a store).
// - FSM states: IDLE, REQ, WAIT, DONE.
//   IDLE: access & !fault -> latch addr/be/wdata/we/size/lane into bus regs, dmem_req<=1, go to REQ; stall_m=1 this cycle.
//     access & fault -> no bus activity, stall_m=0, err_m=1, read_data_m=0, stay IDLE.
//     No access -> stall_m=0. dmem_rvalid/dmem_gnt are ignored in IDLE (stale responses are dropped).
//   REQ: dmem_req=1, bus fields stable. dmem_gnt -> dmem_req<=0, go to WAIT. stall_m=1.
//   WAIT: dmem_rvalid -> capture the extended rdata (0 for a store) into read_data_m, capture dmem_err into err_m, go to DONE. stall_m=1.
//   DONE: stall_m=0; read_data_m/err_m held valid for the M->W capture edge; next state IDLE, err_m cleared.
// - Timeout: counter resets on entry to REQ and increments each cycle in REQ/WAIT. At count==TIMEOUT_CYCLES-1
//   -> dmem_req<=0, read_data_m<=0, err_m<=1, go to DONE.
// - Minimum load/store latency is 3 stall cycles (IDLE, REQ with gnt, WAIT with rvalid), followed by DONE.
// - dmem_rvalid in the same cycle as dmem_gnt is not accepted; the response must arrive in WAIT.
// - Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{wdata_m[7:0]}}; SH be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata_m[15:0]}};
//   SW be=4'hF, wdata=wdata_m. On loads, dmem_be is the same lane mask and dmem_we=0.
// - Load extract: B/BU byte = rdata[8*lane+:8]; H/HU half = rdata[16*addr[1]+:16]. B/H sign-extend; BU/HU zero-extend; W passes rdata.
// - Inputs are sampled only in IDLE. The pipeline is frozen while stall_m=1, so the inputs are stable anyway.
// - Reset mid-transaction: dmem_req drops immediately; any later response is ignored.
// TESTING
// - LW addr=0x100, gnt at +1, rvalid at +2 with rdata=0xDEADBEEF -> dmem_addr=0x100, be=F, stall 3 cycles, read_data_m=0xDEADBEEF in DONE.
// - LB addr=0x203 with rdata=0x80FF_0000 -> be=1000, read_data_m=0xFFFFFF80; same access as LBU -> 0x00000080.
// - SH addr=0x12, wdata_m=0xABCD1234 -> dmem_we=1, addr=0x10, be=1100, wdata=0x12341234, err_m=0.
// - LW addr=0x102 -> no dmem_req, stall_m=0, err_m=1 for 1 cycle; LH addr=0x101 -> same.
// - gnt held low for 3 cycles -> dmem_req stays high with stable addr/be, stall persists. No gnt with TIMEOUT_CYCLES=8 -> err_m=1 after 8 cycles.
// - Assert reset while in WAIT, then raise rvalid -> state IDLE, no stall, no err, read_data_m=0.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: drives one request/grant/response data-bus access per
// load or store, stalls the pipeline until it completes and reports access faults.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_m,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [2:0]  mem_size_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    output logic [31:0] read_data_m,
    output logic        stall_m,
    output logic        err_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsuState;

    lsuState          state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [2:0]       sizeQ, sizeNext;
    logic [1:0]       laneQ, laneNext;
    logic             errQ, errNext;
    logic             reqNext, weNext;
    logic [31:0]      addrNext, wdataNext, dataNext;
    logic [3:0]       beNext;
    logic             stallC, faultC;

    logic             access, misaligned, illegal, isFault;
    logic [3:0]       laneBe;
    logic [31:0]      laneWdata, loadData;
    logic [7:0]       byteSel;
    logic [15:0]      halfSel;

    assign access  = valid_m & (mem_read_m | mem_write_m);
    assign illegal = (mem_size_m == 3'b011) | (mem_size_m[2:1] == 2'b11)
                   | (mem_write_m & mem_size_m[2]);
    assign isFault = misaligned | illegal;

    // Alignment check and store lane placement for the incoming access
    always_comb begin
        misaligned = 1'b0;
        laneBe     = 4'hF;
        laneWdata  = wdata_m;
        case (mem_size_m[1:0])
            2'b00: begin
                laneBe    = 4'b0001 << addr_m[1:0];
                laneWdata = {4{wdata_m[7:0]}};
            end
            2'b01: begin
                misaligned = addr_m[0];
                laneBe     = 4'b0011 << {addr_m[1], 1'b0};
                laneWdata  = {2{wdata_m[15:0]}};
            end
            2'b10: misaligned = |addr_m[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Load extraction uses the size/lane latched at request time
    assign byteSel = 8'(dmem_rdata >> {laneQ, 3'b000});
    assign halfSel = laneQ[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (sizeQ)
            3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
            3'b100:  loadData = {24'd0, byteSel};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b101:  loadData = {16'd0, halfSel};
            default: loadData = dmem_rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        sizeNext  = sizeQ;
        laneNext  = laneQ;
        errNext   = errQ;
        reqNext   = dmem_req;
        weNext    = dmem_we;
        addrNext  = dmem_addr;
        beNext    = dmem_be;
        wdataNext = dmem_wdata;
        dataNext  = read_data_m;
        stallC    = 1'b0;
        faultC    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (isFault) begin
                        faultC = 1'b1;
                    end else begin
                        stallC    = 1'b1;
                        stateNext = REQ;
                        cntNext   = '0;
                        reqNext   = 1'b1;
                        weNext    = mem_write_m;
                        addrNext  = {addr_m[31:2], 2'b00};
                        beNext    = laneBe;
                        wdataNext = laneWdata;
                        sizeNext  = mem_size_m;
                        laneNext  = addr_m[1:0];
                    end
                end
            end
            REQ: begin
                stallC  = 1'b1;
                cntNext = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    reqNext   = 1'b0;
                    dataNext  = '0;
                    errNext   = 1'b1;
                    stateNext = DONE;
                end else if (dmem_gnt) begin
                    reqNext   = 1'b0;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                stallC  = 1'b1;
                cntNext = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    dataNext  = '0;
                    errNext   = 1'b1;
                    stateNext = DONE;
                end else if (dmem_rvalid) begin
                    dataNext  = dmem_we ? 32'd0 : loadData;
                    errNext   = dmem_err;
                    stateNext = DONE;
                end
            end
            DONE: begin
                errNext   = 1'b0;
                dataNext  = '0;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sizeQ       <= '0;
            laneQ       <= '0;
            errQ        <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= '0;
            dmem_wdata  <= '0;
            read_data_m <= '0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            sizeQ       <= sizeNext;
            laneQ       <= laneNext;
            errQ        <= errNext;
            dmem_req    <= reqNext;
            dmem_we     <= weNext;
            dmem_addr   <= addrNext;
            dmem_be     <= beNext;
            dmem_wdata  <= wdataNext;
            read_data_m <= dataNext;
        end
    end

    // Immediate fault and stall flags are forced low while reset is held
    assign stall_m = ~reset & stallC;
    assign err_m   = ~reset & (errQ | faultC);

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: acts as the data-memory bus and checks
// bus fields, stall length, load data and fault reporting.
module tb_lsu_mem_stage;
    localparam int TO    = 8;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m, mem_read_m, mem_write_m;
    logic [2:0]  mem_size_m;
    logic [31:0] addr_m, wdata_m;
    logic [31:0] read_data_m;
    logic        stall_m, err_m;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid, dmem_err;
    logic [31:0] dmem_rdata;

    lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .valid_m(valid_m), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .mem_size_m(mem_size_m), .addr_m(addr_m), .wdata_m(wdata_m),
        .read_data_m(read_data_m), .stall_m(stall_m), .err_m(err_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        int          stalls;
    } expT;

    expT sbQ[$];
    int  testsRun    = 0;
    int  testsFailed = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int sizeBytes(input logic [2:0] size);
        case (size[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic modelFault(input logic wr, input logic [2:0] size, input logic [31:0] addr);
        if (size == 3'b011 || size == 3'b110 || size == 3'b111) return 1'b1;
        if (wr && size[2]) return 1'b1;
        return (int'(addr[1:0]) % sizeBytes(size)) != 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] size, input logic [31:0] addr);
        logic [3:0] be;
        int start = int'(addr[1:0]);
        int n     = sizeBytes(size);
        for (int i = 0; i < 4; i++) be[i] = (i >= start) && (i < start + n);
        return be;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] w;
        int n = sizeBytes(size);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        int n = sizeBytes(size);
        v = rd >> (8 * int'(addr[1:0]));
        if (n == 1) v = size[2] ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        else if (n == 2) v = size[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic runAccess(input string tag, input logic rd, input logic wr, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int gntDelay, input int rvDelay,
                             input logic [31:0] rdata, input logic berr, input logic rvWithGnt);
        expT e, got;
        logic isF, tmo, granted, done;
        int stalls, reqCnt, waitCnt;
        isF = modelFault(wr, size, addr);
        tmo = !isF && (gntDelay + rvDelay + 2 >= TO);
        e.tag    = tag;
        e.err    = isF || tmo || berr;
        e.data   = (isF || tmo || wr) ? 32'd0 : modelLoad(size, addr, rdata);
        e.stalls = isF ? 0 : (tmo ? 1 + TO : gntDelay + rvDelay + 3);
        @(posedge clk); #1;
        valid_m = 1'b1; mem_read_m = rd; mem_write_m = wr; mem_size_m = size;
        addr_m = addr; wdata_m = wd;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
        sbQ.push_back(e);
        stalls = 0; reqCnt = 0; waitCnt = 0; granted = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
                if (dmem_req) begin
                    checkVal({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
                    checkVal({tag, ".be"}, 32'(dmem_be), 32'(modelBe(size, addr)));
                    if (reqCnt == 0) begin
                        checkVal({tag, ".we"}, 32'(dmem_we), 32'(wr));
                        if (wr) checkVal({tag, ".wdata"}, dmem_wdata, modelWdata(size, wd));
                    end
                    if (reqCnt == gntDelay) begin
                        dmem_gnt = 1'b1;
                        granted  = 1'b1;
                        if (rvWithGnt) begin
                            dmem_rvalid = 1'b1;
                            dmem_rdata  = ~rdata;
                        end
                    end
                    reqCnt++;
                end else if (granted) begin
                    if (waitCnt == rvDelay) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = rdata;
                        dmem_err    = berr;
                    end
                    waitCnt++;
                end
            end
            @(negedge clk);
            if (stall_m) begin
                stalls++;
            end else begin
                done = 1'b1;
                if (sbQ.size() == 0) begin
                    checkVal({tag, ".sb_empty"}, 32'd1, 32'd0);
                end else begin
                    got = sbQ.pop_front();
                    checkVal({got.tag, ".data"}, read_data_m, got.data);
                    checkVal({got.tag, ".err"}, 32'(err_m), 32'(got.err));
                    checkVal({got.tag, ".stalls"}, 32'(stalls), 32'(got.stalls));
                    checkVal({got.tag, ".req_low"}, 32'(dmem_req), 32'd0);
                end
            end
        end
        if (!done) checkVal({tag, ".no_completion"}, 32'(stall_m), 32'd0);
        @(posedge clk); #1;
        valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0;
        @(negedge clk);
        checkVal({tag, ".err_cleared"}, 32'(err_m), 32'd0);
        checkVal({tag, ".idle_stall"}, 32'(stall_m), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
        $fatal(1);
    end

    initial begin
        logic [2:0]  rsz;
        logic [2:0]  sizes [5];
        logic [31:0] raddr;
        sizes[0] = 3'b000; sizes[1] = 3'b001; sizes[2] = 3'b010; sizes[3] = 3'b100; sizes[4] = 3'b101;
        reset = 1'b1;
        valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0; mem_size_m = '0;
        addr_m = '0; wdata_m = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;
        @(negedge clk);
        checkVal("rst.stall", 32'(stall_m), 32'd0);
        checkVal("rst.err", 32'(err_m), 32'd0);
        checkVal("rst.req", 32'(dmem_req), 32'd0);
        checkVal("rst.data", read_data_m, 32'd0);
        checkVal("rst.be", 32'(dmem_be), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        runAccess("lw_basic", 1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF, 0, 0);
        runAccess("lb_neg", 1, 0, 3'b000, 32'h203, 0, 0, 0, 32'h80FF_0000, 0, 0);
        runAccess("lbu", 1, 0, 3'b100, 32'h203, 0, 0, 0, 32'h80FF_0000, 0, 0);
        runAccess("sh", 0, 1, 3'b001, 32'h12, 32'hABCD1234, 0, 1, 0, 0, 0);
        runAccess("sb", 0, 1, 3'b000, 32'h31, 32'h000000A5, 1, 0, 0, 0, 0);
        runAccess("rw_both", 1, 1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 0, 32'h11111111, 0, 0);
        runAccess("lw_mis", 1, 0, 3'b010, 32'h102, 0, 0, 0, 0, 0, 0);
        runAccess("lh_mis", 1, 0, 3'b001, 32'h101, 0, 0, 0, 0, 0, 0);
        runAccess("sbu_ill", 0, 1, 3'b100, 32'h40, 32'h1, 0, 0, 0, 0, 0);
        runAccess("sz3_ill", 1, 0, 3'b011, 32'h40, 0, 0, 0, 0, 0, 0);
        runAccess("gnt_late", 1, 0, 3'b010, 32'h84, 0, 3, 0, 32'h01234567, 0, 0);
        runAccess("tmo_req", 1, 0, 3'b010, 32'h88, 0, NEVER, 0, 32'h5, 0, 0);
        runAccess("tmo_wait", 0, 1, 3'b010, 32'h8C, 32'h9, 0, NEVER, 0, 0, 0);
        runAccess("bus_err", 1, 0, 3'b001, 32'h2, 0, 0, 1, 32'h8001_0000, 1, 0);
        runAccess("rv_gnt", 1, 0, 3'b101, 32'h6, 0, 0, 2, 32'h1234_F00D, 0, 1);

        for (int k = 0; k < 6; k++) begin
            rsz   = sizes[$urandom_range(0, 4)];
            raddr = $urandom & ~32'(sizeBytes(rsz) - 1);
            runAccess($sformatf("rnd%0d", k), 1, 0, rsz, raddr, 0,
                      $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 0, 0);
        end

        // Stale response while idle must be dropped
        @(posedge clk); #1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF; dmem_err = 1'b1;
        @(negedge clk);
        checkVal("stale.stall", 32'(stall_m), 32'd0);
        checkVal("stale.err", 32'(err_m), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0; dmem_err = 1'b0;
        @(negedge clk);
        checkVal("stale.data", read_data_m, 32'd0);

        // Reset during WAIT, then a late response
        @(posedge clk); #1;
        valid_m = 1'b1; mem_read_m = 1'b1; mem_size_m = 3'b010; addr_m = 32'h40;
        @(posedge clk); #1;
        checkVal("rstw.req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        reset = 1'b1; valid_m = 1'b0; mem_read_m = 1'b0;
        @(negedge clk);
        checkVal("rstw.stall", 32'(stall_m), 32'd0);
        checkVal("rstw.err", 32'(err_m), 32'd0);
        checkVal("rstw.req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        checkVal("rstw.post_stall", 32'(stall_m), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        checkVal("rstw.post_data", read_data_m, 32'd0);
        checkVal("rstw.post_err", 32'(err_m), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
